interrupt_ack_controller: RTL

- Downstream neighbour of the interrupt request register. Takes its pending-request vector, applies the mask, and resolves priority against the in-service register (ISR).
- Drives INT and runs the two-pulse 8086-mode INTA sequence, placing the vector on the data bus during the second pulse.
- Returns a one-cycle clear pulse to the request register for the acknowledged line. Handles EOI commands (non-specific, specific, automatic).

---
 rtl/interrupt_ack_controller.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_ack_controller.sv
// Interrupt acknowledge controller: mask + priority resolution against the ISR,
// INT generation, two-pulse 8086 INTA sequence with vector drive, and EOI handling.
// Latency: INT one cycle after eligibility changes; vector on the bus one cycle after second INTA fall.
// Backpressure: none; the sequence advances only on INTA edges, and EOI pulses are applied immediately.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   interruptRequest       pending lines from the request register
//   interruptMask          1 = line masked
//   vectorBase             vector bits T7..T3
//   autoEOI                clear the ISR bit automatically at the end of the second INTA
//   nonSpecificEOI         clear the highest-priority ISR bit (one-cycle pulse)
//   specificEOI/eoiLevel   clear ISR[eoiLevel] (one-cycle pulse, wins over non-specific)
//   intaN                  INTA level, active-low, synchronous to clk
//   INT                    interrupt request to the CPU
//   clearInterruptRequest  one-hot, one-cycle clear back to the request register
//   inService              ISR contents
//   dataOut/dataOutEnable  vector byte and its bus drive enable
//
// Optional build macro INTERRUPT_ACK_ROTATE_PRIORITY_EN adds the rotateOnEOI input and a
// lowest-priority register so priority rotates on EOI; without it IR0 is always highest.

module interrupt_ack_controller #(
    parameter int NUM_IRQ        = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] interruptRequest,
    input  logic [7:0] interruptMask,
    input  logic [4:0] vectorBase,
    input  logic       autoEOI,
    input  logic       nonSpecificEOI,
    input  logic       specificEOI,
    input  logic [2:0] eoiLevel,
`ifdef INTERRUPT_ACK_ROTATE_PRIORITY_EN
    input  logic       rotateOnEOI,
`endif
    input  logic       intaN,
    output logic       INT,
    output logic [7:0] clearInterruptRequest,
    output logic [7:0] inService,
    output logic [7:0] dataOut,
    output logic       dataOutEnable
);

    // The encoding below is hard-wired for eight lines.
    if (NUM_IRQ != 8) begin : g_num_irq_check
        $error("interrupt_ack_controller: NUM_IRQ must be 8");
    end

    localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LEVEL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK1   = 2'd1,
        WAIT2  = 2'd2,
        VECTOR = 2'd3
    } state_t;

    state_t     state_q;
    logic       prev_inta_q;
    logic       int_q;
    logic [7:0] clr_q;
    logic [7:0] isr_q, isr_d;
    logic [7:0] dout_q;
    logic       oe_q;
    logic [2:0] sel_q;
    logic       spurious_q;

    // Rotate a vector so that index 0 is the current highest-priority level.
    function automatic logic [7:0] rotate_vec(input logic [7:0] v, input logic [2:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[3'(b + 3'(i))];
        end
        return r;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty; callers check for that).
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [2:0] base;       // level with the highest priority
    logic [7:0] pending, pend_rot, isr_rot;
    logic [2:0] pend_idx, isr_idx, cand, isr_top;
    logic       pend_any, isr_any, eligible;
    logic       fall_inta, rise_inta, auto_clear;

`ifdef INTERRUPT_ACK_ROTATE_PRIORITY_EN
    logic [2:0] lowest_q, lowest_d;
    assign base = lowest_q + 3'd1;
`else
    assign base = 3'd0;
`endif

    assign pending   = interruptRequest & ~interruptMask;
    assign pend_rot  = rotate_vec(pending, base);
    assign isr_rot   = rotate_vec(isr_q, base);
    assign pend_idx  = first_set(pend_rot);
    assign isr_idx   = first_set(isr_rot);
    assign pend_any  = |pending;
    assign isr_any   = |isr_q;
    assign cand      = base + pend_idx;
    assign isr_top   = base + isr_idx;
    // Fully nested: any in-service level at or above the candidate blocks it.
    assign eligible  = pend_any && (!isr_any || (pend_idx < isr_idx));

    assign fall_inta = prev_inta_q & ~intaN;
    assign rise_inta = ~prev_inta_q & intaN;
    assign auto_clear = (state_q == VECTOR) && rise_inta && autoEOI && !spurious_q;

    // ISR next state: all clears first, then the acknowledge set, so a freshly
    // acknowledged level is never lost to a coincident EOI.
    always_comb begin
        isr_d = isr_q;
        if (specificEOI) begin
            isr_d[eoiLevel] = 1'b0;
        end else if (nonSpecificEOI && isr_any) begin
            isr_d[isr_top] = 1'b0;
        end
        if (auto_clear) begin
            isr_d[sel_q] = 1'b0;
        end
        if ((state_q == IDLE) && fall_inta && int_q) begin
            isr_d[cand] = 1'b1;
        end
    end

`ifdef INTERRUPT_ACK_ROTATE_PRIORITY_EN
    always_comb begin
        lowest_d = lowest_q;
        if (rotateOnEOI && nonSpecificEOI && !specificEOI && isr_any) begin
            lowest_d = isr_top;
        end
        if (rotateOnEOI && auto_clear) begin
            lowest_d = sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lowest_q <= 3'd7;
        else       lowest_q <= lowest_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_inta_q <= 1'b1;
            int_q       <= 1'b0;
            clr_q       <= 8'h00;
            isr_q       <= 8'h00;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            sel_q       <= 3'd0;
            spurious_q  <= 1'b0;
        end else begin
            prev_inta_q <= intaN;
            isr_q       <= isr_d;
            clr_q       <= 8'h00;
            case (state_q)
                IDLE: begin
                    if (fall_inta) begin
                        state_q <= ACK1;
                        int_q   <= 1'b0;
                        if (int_q) begin
                            sel_q      <= cand;
                            clr_q      <= 8'b1 << cand;
                            spurious_q <= 1'b0;
                        end else begin
                            sel_q      <= SPUR_LVL;
                            spurious_q <= 1'b1;
                        end
                    end else begin
                        int_q <= eligible;
                    end
                end
                ACK1: begin
                    int_q <= 1'b0;
                    oe_q  <= 1'b0;
                    if (rise_inta) state_q <= WAIT2;
                end
                WAIT2: begin
                    int_q <= 1'b0;
                    if (fall_inta) begin
                        state_q <= VECTOR;
                        dout_q  <= {vectorBase, sel_q};
                        oe_q    <= 1'b1;
                    end
                end
                VECTOR: begin
                    int_q <= 1'b0;
                    if (rise_inta) begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    int_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign INT                   = int_q;
    assign clearInterruptRequest = clr_q;
    assign inService             = isr_q;
    assign dataOut               = dout_q;
    assign dataOutEnable         = oe_q;

endmodule
